// File: rtl/cpu_pkg.sv
// Shared 6502 core definitions: ALU op codes and read-modify-write sequencer types.
package cpu_pkg;

   localparam logic [2:0] ALU_ASL = 3'b100;
   localparam logic [2:0] ALU_LSR = 3'b101;

   // op[5] selects bi as the unary source, op[4] gates carry-in
   localparam logic [5:0] ALU_NOP     = 6'b000111;
   localparam logic [5:0] RMW_ALU_INC = 6'b101010;
   localparam logic [5:0] RMW_ALU_DEC = 6'b101011;
   localparam logic [5:0] RMW_ALU_ASL = {3'b100, ALU_ASL};
   localparam logic [5:0] RMW_ALU_ROL = {3'b110, ALU_ASL};
   localparam logic [5:0] RMW_ALU_LSR = {3'b100, ALU_LSR};
   localparam logic [5:0] RMW_ALU_ROR = {3'b110, ALU_LSR};

   typedef enum logic [2:0] {
      RMW_INC = 3'd0,
      RMW_DEC = 3'd1,
      RMW_ASL = 3'd2,
      RMW_LSR = 3'd3,
      RMW_ROL = 3'd4,
      RMW_ROR = 3'd5
   } rmw_op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DUMMY = 2'd2,
      ST_WRITE = 2'd3
   } rmw_state_t;

   function automatic logic [5:0] rmw_alu_op(input rmw_op_t op);
      logic [5:0] code;
      code = ALU_NOP;
      case (op)
         RMW_INC: code = RMW_ALU_INC;
         RMW_DEC: code = RMW_ALU_DEC;
         RMW_ASL: code = RMW_ALU_ASL;
         RMW_LSR: code = RMW_ALU_LSR;
         RMW_ROL: code = RMW_ALU_ROL;
         RMW_ROR: code = RMW_ALU_ROR;
         default: code = ALU_NOP;
      endcase
      return code;
   endfunction

   // INC/DEC leave C alone; only the shifts and rotates update it
   function automatic logic rmw_writes_c(input rmw_op_t op);
      return (op != RMW_INC) && (op != RMW_DEC);
   endfunction

endpackage

// File: rtl/rmw_seq.sv
// Read-modify-write sequencer: read / dummy-write / final-write bus pattern
// driving the shared ALU for INC, DEC, ASL, LSR, ROL, ROR on memory operands.
module rmw_seq
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  op_sel,
   input  logic [15:0] ea,
   input  logic        c_in,
   input  logic        rdy,
   input  logic [7:0]  data_i,
   output logic [15:0] addr_o,
   output logic [7:0]  data_o,
   output logic        we,
   output logic [5:0]  alu_op,
   output logic [7:0]  alu_bi,
   output logic [7:0]  alu_ai,
   output logic        alu_ci,
   input  logic [7:0]  alu_out,
   input  logic        alu_n,
   input  logic        alu_z,
   input  logic        alu_c,
   output logic        busy,
   output logic        done,
   output logic        nz_we,
   output logic        c_we
);

   rmw_state_t r_state, w_next;
   logic [15:0] r_ea;
   rmw_op_t     r_op;
   logic        r_c;
   logic [7:0]  r_operand;
   logic        w_accept;
   logic        w_unused_flags;

   // Flags go straight from the ALU to the status register; only strobes come from here.
   assign w_unused_flags = ^{alu_n, alu_z, alu_c};
   assign w_accept       = start && (op_sel < 3'd6);
   assign alu_ai         = 8'h00;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_ea      <= 16'h0000;
         r_op      <= RMW_INC;
         r_c       <= 1'b0;
         r_operand <= 8'h00;
      end else begin
         r_state <= w_next;
         if (r_state == ST_IDLE && w_accept) begin
            r_ea <= ea;
            r_op <= rmw_op_t'(op_sel);
            r_c  <= c_in;
         end
         if (r_state == ST_READ && rdy)
            r_operand <= data_i;
      end
   end

   always_comb begin
      w_next = r_state;
      addr_o = r_ea;
      data_o = 8'h00;
      we     = 1'b0;
      alu_op = ALU_NOP;
      alu_bi = 8'h00;
      alu_ci = 1'b0;
      busy   = 1'b1;
      done   = 1'b0;
      nz_we  = 1'b0;
      c_we   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            busy = 1'b0;
            if (w_accept) w_next = ST_READ;
         end
         ST_READ: begin
            if (rdy) w_next = ST_DUMMY;
         end
         ST_DUMMY: begin
            // original value goes back out while the ALU registers its result
            we     = 1'b1;
            data_o = r_operand;
            alu_op = rmw_alu_op(r_op);
            alu_bi = r_operand;
            alu_ci = r_c;
            w_next = ST_WRITE;
         end
         ST_WRITE: begin
            we     = 1'b1;
            data_o = alu_out;
            done   = 1'b1;
            nz_we  = 1'b1;
            c_we   = rmw_writes_c(r_op);
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_rmw_seq.sv
// Self-checking bench for rmw_seq: behavioural memory, ALU and status register,
// a per-cycle bus/strobe model, directed cases and randomized traffic.
module tb_rmw_seq;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, start, c_in, rdy;
   logic [2:0]  op_sel;
   logic [15:0] ea, addr_o;
   logic [7:0]  data_i, data_o, alu_bi, alu_ai, alu_out;
   logic [5:0]  alu_op;
   logic        we, alu_ci, alu_n, alu_z, alu_c, busy, done, nz_we, c_we;

   int cnt_pass = 0;
   int cnt_tot  = 0;
   bit chk_en   = 1'b0;

   rmw_seq dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op_sel(op_sel), .ea(ea),
      .c_in(c_in), .rdy(rdy), .data_i(data_i), .addr_o(addr_o), .data_o(data_o),
      .we(we), .alu_op(alu_op), .alu_bi(alu_bi), .alu_ai(alu_ai), .alu_ci(alu_ci),
      .alu_out(alu_out), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c),
      .busy(busy), .done(done), .nz_we(nz_we), .c_we(c_we)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      cnt_tot++;
      if (act === exp) cnt_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   // ---------------- environment: memory, ALU, status register ----------------
   logic [7:0] mem [0:65535];
   assign data_i = mem[addr_o];
   always @(posedge clk) if (we === 1'b1) mem[addr_o] <= data_o;

   function automatic logic [8:0] alu_f(input logic [5:0] op, input logic [7:0] ai,
                                        input logic [7:0] bi, input logic ci);
      logic [7:0] o;
      logic c, cin;
      cin = op[4] ? ci : 1'b0;
      if (op == RMW_ALU_INC)                          begin o = bi + 8'd1; c = (bi == 8'hFF); end
      else if (op == RMW_ALU_DEC)                     begin o = bi - 8'd1; c = (bi == 8'h00); end
      else if (op[5] && op[2:0] == ALU_ASL)           begin o = {bi[6:0], cin}; c = bi[7]; end
      else if (op[5] && op[2:0] == ALU_LSR)           begin o = {cin, bi[7:1]}; c = bi[0]; end
      else                                            begin o = ai; c = 1'b0; end
      return {c, o};
   endfunction

   always @(posedge clk) {alu_c, alu_out} <= alu_f(alu_op, alu_ai, alu_bi, alu_ci);
   assign alu_n = alu_out[7];
   assign alu_z = (alu_out == 8'h00);

   logic sr_n = 1'b0, sr_z = 1'b0, sr_c = 1'b0;
   logic sr_ld = 1'b0, sr_ld_c = 1'b0;
   always @(posedge clk) begin
      if (nz_we === 1'b1) begin sr_n <= alu_n; sr_z <= alu_z; end
      if (c_we === 1'b1) sr_c <= alu_c;
      else if (sr_ld) sr_c <= sr_ld_c;
   end
   assign c_in = sr_c;

   // ---------------- reference model ----------------
   // {c, n, z, result} of an RMW instruction on value v with incoming carry c
   function automatic logic [10:0] ref_f(input logic [2:0] op, input logic [7:0] v, input logic c);
      logic [7:0] r;
      logic co;
      co = c;
      case (op)
         3'd0: r = v + 8'd1;
         3'd1: r = v - 8'd1;
         3'd2: begin r = v << 1;          co = v[7]; end
         3'd3: begin r = v >> 1;          co = v[0]; end
         3'd4: begin r = {v[6:0], c};     co = v[7]; end
         default: begin r = {c, v[7:1]};  co = v[0]; end
      endcase
      return {co, r[7], (r == 8'h00), r};
   endfunction

   function automatic logic [5:0] exp_code(input logic [2:0] op);
      case (op)
         3'd0: return 6'b101010;
         3'd1: return 6'b101011;
         3'd2: return 6'b100100;
         3'd3: return 6'b100101;
         3'd4: return 6'b110100;
         default: return 6'b110101;
      endcase
   endfunction

   // m_k: -1 no sequence, else index of the bus cycle within read/dummy/write
   int          m_k = -1;
   logic [15:0] m_ea = '0;
   logic [2:0]  m_op = '0;
   logic        m_ci = 1'b0;
   logic [7:0]  m_orig = '0;
   logic        m_n = 1'b0, m_z = 1'b0, m_c = 1'b0;
   logic [10:0] m_ref;
   assign m_ref = ref_f(m_op, m_orig, m_ci);

   always @(posedge clk) begin
      if (m_k == 2) begin m_n <= m_ref[9]; m_z <= m_ref[8]; end
      if (m_k == 2 && m_op >= 3'd2) m_c <= m_ref[10];
      else if (sr_ld) m_c <= sr_ld_c;
      if (!rst_n) m_k <= -1;
      else case (m_k)
         -1: if (start && op_sel < 3'd6) begin
                m_k <= 0; m_ea <= ea; m_op <= op_sel; m_ci <= c_in;
             end
         0:  if (rdy) begin m_orig <= mem[m_ea]; m_k <= 1; end
         1:  m_k <= 2;
         default: m_k <= -1;
      endcase
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy",  16'(busy),  16'(m_k >= 0));
         chk("we",    16'(we),    16'(m_k >= 1));
         chk("done",  16'(done),  16'(m_k == 2));
         chk("nz_we", 16'(nz_we), 16'(m_k == 2));
         chk("c_we",  16'(c_we),  16'(m_k == 2 && m_op >= 3'd2));
         if (m_k >= 0) chk("addr_o", addr_o, m_ea);
         if (m_k == -1) chk("data_o_idle", 16'(data_o), 16'h0);
         if (m_k == 1) begin
            chk("data_o_dummy", 16'(data_o), 16'(m_orig));
            chk("alu_op", 16'(alu_op), 16'(exp_code(m_op)));
            chk("alu_bi", 16'(alu_bi), 16'(m_orig));
            chk("alu_ci", 16'(alu_ci), 16'(m_ci));
         end else begin
            chk("alu_op_nop", 16'(alu_op), 16'h0007);
            chk("alu_bi_nop", 16'(alu_bi), 16'h0);
            chk("alu_ci_nop", 16'(alu_ci), 16'h0);
         end
         if (m_k == 2) chk("data_o_final", 16'(data_o), 16'(m_ref[7:0]));
         chk("alu_ai", 16'(alu_ai), 16'h0);
         chk("sr_nzc", 16'({sr_n, sr_z, sr_c}), 16'({m_n, m_z, m_c}));
      end
   end

   logic [7:0] wq[$];
   always @(negedge clk) if (chk_en && we === 1'b1) wq.push_back(data_o);

   // ---------------- directed helpers ----------------
   task automatic load_c(input logic v);
      sr_ld = 1'b1; sr_ld_c = v;
      @(posedge clk); #1;
      sr_ld = 1'b0;
   endtask

   // Called 1ns after a clock edge; returns cycles from accept edge to done (-1 on timeout).
   task automatic run_seq(input logic [2:0] op, input logic [15:0] a, input int stall,
                          input bit poke, output int lat);
      start = 1'b1; op_sel = op; ea = a; rdy = (stall > 0) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      lat = -1;
      for (int n = 1; n <= 20; n++) begin
         rdy = (n <= stall) ? 1'b0 : 1'b1;
         if (poke && n == stall + 2) begin start = 1'b1; op_sel = 3'd0; end
         else start = 1'b0;
         @(negedge clk);
         if (done === 1'b1 && lat < 0) lat = n;
         @(posedge clk); #1;
         if (lat >= 0) break;
      end
      start = 1'b0; rdy = 1'b1;
   endtask

   int lat;

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] <= 8'($urandom);
      rst_n = 1'b0; start = 1'b0; rdy = 1'b1; op_sel = 3'd0; ea = 16'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy",   16'(busy),   16'h0);
      chk("rst_we",     16'(we),     16'h0);
      chk("rst_done",   16'(done),   16'h0);
      chk("rst_nz_we",  16'(nz_we),  16'h0);
      chk("rst_c_we",   16'(c_we),   16'h0);
      chk("rst_addr",   addr_o,      16'h0);
      chk("rst_data",   16'(data_o), 16'h0);
      chk("rst_alu_op", 16'(alu_op), 16'h0007);
      chk("rst_alu_bi", 16'(alu_bi), 16'h0);
      chk("rst_alu_ci", 16'(alu_ci), 16'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk_en = 1'b1;

      // INC 0x7F at 0x0010
      mem[16'h0010] <= 8'h7F;
      load_c(1'b0);
      wq.delete();
      run_seq(3'd0, 16'h0010, 0, 1'b0, lat);
      chk("inc_lat", 16'(lat), 16'd3);
      chk("inc_mem", 16'(mem[16'h0010]), 16'h0080);
      chk("inc_nz",  16'({sr_n, sr_z}), 16'b10);
      chk("inc_nwr", 16'(wq.size()), 16'd2);
      if (wq.size() == 2) begin
         chk("inc_wr0", 16'(wq[0]), 16'h007F);
         chk("inc_wr1", 16'(wq[1]), 16'h0080);
      end

      // DEC 0x01 with C=1: C must survive
      mem[16'h0020] <= 8'h01;
      load_c(1'b1);
      run_seq(3'd1, 16'h0020, 0, 1'b0, lat);
      chk("dec_mem", 16'(mem[16'h0020]), 16'h0000);
      chk("dec_nzc", 16'({sr_n, sr_z, sr_c}), 16'b011);

      // ROL 0x80 with C=1
      mem[16'h0030] <= 8'h80;
      load_c(1'b1);
      run_seq(3'd4, 16'h0030, 0, 1'b0, lat);
      chk("rol_mem", 16'(mem[16'h0030]), 16'h0001);
      chk("rol_nzc", 16'({sr_n, sr_z, sr_c}), 16'b001);

      // ROR 0x01 with C=0
      mem[16'h0031] <= 8'h01;
      load_c(1'b0);
      run_seq(3'd5, 16'h0031, 0, 1'b0, lat);
      chk("ror_mem", 16'(mem[16'h0031]), 16'h0000);
      chk("ror_nzc", 16'({sr_n, sr_z, sr_c}), 16'b011);

      // LSR with a 2-cycle read stall and a start poked during the dummy write
      mem[16'h0040] <= 8'h02;
      run_seq(3'd3, 16'h0040, 2, 1'b1, lat);
      chk("stall_lat", 16'(lat), 16'd5);
      @(negedge clk);
      chk("stall_nobusy", 16'(busy), 16'h0);
      @(posedge clk); #1;
      chk("stall_mem", 16'(mem[16'h0040]), 16'h0001);

      // reset asserted during the dummy write
      mem[16'h0050] <= 8'h33;
      start = 1'b1; op_sel = 3'd0; ea = 16'h0050;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1; rst_n = 1'b0;
      @(posedge clk); #1; rst_n = 1'b1;
      @(negedge clk);
      chk("rstmid_busy", 16'(busy), 16'h0);
      chk("rstmid_we",   16'(we),   16'h0);
      chk("rstmid_done", 16'(done), 16'h0);
      @(posedge clk); #1;
      chk("rstmid_mem", 16'(mem[16'h0050]), 16'h0033);
      run_seq(3'd0, 16'h0050, 0, 1'b0, lat);
      chk("rstmid_lat",  16'(lat), 16'd3);
      chk("rstmid_mem2", 16'(mem[16'h0050]), 16'h0034);

      // invalid op_sel
      start = 1'b1; op_sel = 3'd7; ea = 16'h0060;
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk);
      chk("inv_busy", 16'(busy), 16'h0);
      @(posedge clk); #1;

      // randomized traffic against the per-cycle model
      for (int i = 0; i < 4000; i++) begin
         start   = ($urandom_range(0, 2) == 0);
         op_sel  = 3'($urandom);
         ea      = 16'h0100 + 16'($urandom_range(0, 7));
         rdy     = ($urandom_range(0, 3) != 0);
         rst_n   = ($urandom_range(0, 63) != 0);
         sr_ld   = ($urandom_range(0, 15) == 0);
         sr_ld_c = 1'($urandom);
         @(posedge clk); #1;
      end
      rst_n = 1'b1; start = 1'b0; rdy = 1'b1; sr_ld = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", cnt_pass, cnt_tot);
      $finish;
   end

endmodule
